// File: rtl/iter_divider_pkg.sv
// Shared constants and FSM state type for the iterative divider.
package iter_divider_pkg;

  localparam int unsigned DIV_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DIV_DATA_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/iter_divider_if.sv
// Operand and result handshakes of the iterative divider.
interface iter_divider_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  is_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit and
// subtract the divisor magnitude if it fits.
module iter_divider_div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  quo_msb,
  input  logic [DATA_WIDTH-1:0] divisor_mag,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // rem < divisor_mag always holds, so a non-negative trial fits in DATA_WIDTH bits.
  always_comb begin
    shifted = {rem, quo_msb};
    trial   = shifted - {1'b0, divisor_mag};
    q_bit   = ~trial[DATA_WIDTH];
    rem_next = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned divider, one quotient bit per cycle, with
// valid/ready handshakes on operands and results.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_divider_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_START = CNT_WIDTH'(DATA_WIDTH);

  div_state_t            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] rem_r, quo_r, dmag_r;
  logic                  q_neg, r_neg;
  logic                  in_ready_r, out_valid_r, dbz_r;
  logic [DATA_WIDTH-1:0] quotient_r, remainder_r;

  logic [DATA_WIDTH-1:0] rem_next, quo_next;
  logic [DATA_WIDTH-1:0] dividend_mag, divisor_mag;
  logic                  q_bit;

  iter_divider_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem         (rem_r),
    .quo_msb     (quo_r[DATA_WIDTH-1]),
    .divisor_mag (dmag_r),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  always_comb begin
    quo_next     = {quo_r[DATA_WIDTH-2:0], q_bit};
    dividend_mag = (bus.is_signed && bus.dividend[DATA_WIDTH-1]) ? -bus.dividend : bus.dividend;
    divisor_mag  = (bus.is_signed && bus.divisor[DATA_WIDTH-1])  ? -bus.divisor  : bus.divisor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dmag_r      <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            if (bus.divisor == '0) begin
              // Divide by zero bypasses iteration and sign fix-up entirely.
              state       <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end else begin
              state  <= BUSY;
              cnt    <= CNT_START;
              rem_r  <= '0;
              quo_r  <= dividend_mag;
              dmag_r <= divisor_mag;
              q_neg  <= bus.is_signed & (bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1]);
              r_neg  <= bus.is_signed & bus.dividend[DATA_WIDTH-1];
            end
          end
        end
        BUSY: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          cnt   <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            dbz_r       <= 1'b0;
            quotient_r  <= q_neg ? -quo_next : quo_next;
            remainder_r <= r_neg ? -rem_next : rem_next;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_iter_divider.sv
// Randomized and directed checks of iter_divider against a 64-bit arithmetic model.
module tb_iter_divider;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  iter_divider_if #(.DATA_WIDTH(32)) bus ();

  iter_divider #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact division in 64-bit signed arithmetic, truncated to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else begin
      if (s) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
      else   begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.dividend = a; bus.divisor = b; bus.is_signed = s; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 ||
        bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic dz; int lat;
    do_div(32'd100, 32'd7, 1'b0, q, r, dz, lat);
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
      errors++; $display("FAIL unsigned_100_7: q=%0d r=%0d dz=%b required 14 2 0", q, r, dz);
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL latency: got %0d required 33", lat); end
    do_div(32'hFFFF_FFFF, 32'd2, 1'b0, q, r, dz, lat);
    checks++;
    if (q !== 32'h7FFF_FFFF || r !== 32'd1) begin
      errors++; $display("FAIL unsigned_max_2: q=%h r=%h required 7fffffff 00000001", q, r);
    end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic dz; int lat;
    do_div(32'hFFFF_FF9C, 32'd7, 1'b1, q, r, dz, lat);
    checks++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || dz !== 1'b0) begin
      errors++; $display("FAIL signed_m100_7: q=%h r=%h required fffffff2 fffffffe", q, r);
    end
    do_div(32'd100, 32'hFFFF_FFF9, 1'b1, q, r, dz, lat);
    checks++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'd2) begin
      errors++; $display("FAIL signed_100_m7: q=%h r=%h required fffffff2 00000002", q, r);
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] q, r; logic dz; int lat;
    for (int s = 0; s < 2; s++) begin
      do_div(32'd1234, 32'd0, s[0], q, r, dz, lat);
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'd1234 || dz !== 1'b1 || lat !== 1) begin
        errors++;
        $display("FAIL div_by_zero s=%0d: q=%h r=%0d dz=%b lat=%0d required ffffffff 1234 1 1",
                 s, q, r, dz, lat);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic dz; int lat;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dz, lat);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
      errors++; $display("FAIL overflow: q=%h r=%h dz=%b required 80000000 0 0", q, r, dz);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    bus.dividend = 32'd1000; bus.divisor = 32'd9; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0]; bus.dividend = $urandom; bus.divisor = $urandom;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 32'd111 ||
          bus.remainder !== 32'd1) begin
        errors++;
        $display("FAIL backpressure cyc=%0d: vld=%b rdy=%b q=%0d r=%0d required 1 0 111 1",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL no_spurious_accept: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] q, r; logic dz; int lat;
    bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_busy: rdy=%b vld=%b q=%h r=%h required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_div(32'd9, 32'd3, 1'b0, q, r, dz, lat);
    checks++;
    if (q !== 32'd3 || r !== 32'd0) begin
      errors++; $display("FAIL after_reset_9_3: q=%0d r=%0d required 3 0", q, r);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er; logic s, dz, edz; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'($urandom_range(1, 16));
        1: b = -32'($urandom_range(1, 16));
        2: b = 32'd0;
        3: a = 32'($urandom_range(0, 50));
        4: a = 32'h8000_0000;
        default: ;
      endcase
      model(a, b, s, eq, er, edz);
      do_div(a, b, s, q, r, dz, lat);
      checks++;
      if (q !== eq || r !== er || dz !== edz) begin
        errors++;
        $display("FAIL random#%0d a=%h b=%h s=%b: q=%h r=%h dz=%b required %h %h %b",
                 i, a, b, s, q, r, dz, eq, er, edz);
      end
      checks++;
      if (lat !== ((b == 32'd0) ? 1 : 33)) begin
        errors++; $display("FAIL random_latency#%0d: got %0d required %0d", i, lat, (b == 32'd0) ? 1 : 33);
      end
      if (b != 32'd0) begin
        checks++;
        if (32'(q * b + r) !== a) begin
          errors++; $display("FAIL identity#%0d: q*b+r=%h required %h", i, 32'(q * b + r), a);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.is_signed = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle 32-bit integer divider. It computes quotient and remainder by restoring shift-subtract, one quotient bit per cycle, using a (DATA_WIDTH+1)-bit subtractor.
- It is the iterative counterpart to the combinational ALU: the ALU consumes operands and produces a result in the same cycle; this block accepts operands through a valid/ready handshake and returns results through a second valid/ready handshake.
- It sits beside the ALU in the execute stage and serves DIV/DIVU/REM/REMU-type operations.

Parameters:
- DATA_WIDTH, 32: operand and result width.
- CNT_WIDTH, 6: iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: divider can accept operands.
- dividend, input, DATA_WIDTH: numerator.
- divisor, input, DATA_WIDTH: denominator.
- is_signed, input, 1: 1 selects two's-complement division, 0 selects unsigned.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, DATA_WIDTH: quotient result.
- remainder, output, DATA_WIDTH: remainder result.
- div_by_zero, output, 1: the divisor of this result was 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Reset is honoured mid-operation and the in-flight division is discarded.
- FSM states: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE -> BUSY on in_valid && in_ready. Captured on the accept edge:
  - magnitudes |dividend| and |divisor|; magnitudes are taken only when is_signed=1.
  - q_neg = is_signed & (dividend[MSB] ^ divisor[MSB]).
  - r_neg = is_signed & dividend[MSB].
  - raw dividend, for the divide-by-zero case.
  - counter=DATA_WIDTH; partial remainder=0.
- IDLE -> DONE instead, if divisor==0 at accept:
  - quotient = all ones.
  - remainder = raw dividend.
  - div_by_zero=1.
  - No sign fix-up is applied. Latency is 1 cycle.
- BUSY, each cycle:
  - shift {rem,quo} left by 1.
  - trial = rem_shifted − divisor_mag, computed at DATA_WIDTH+1 bits. trial non-negative means the MSB is 0.
  - If trial >= 0: rem = trial and quo[0]=1. Otherwise rem is kept and quo[0]=0.
  - counter decrements.
  - When counter reaches 1 and this step completes, go to DONE. Results are registered with sign fix-up: quotient = q_neg ? −quo : quo; remainder = r_neg ? −rem : rem.
- Latency: a non-zero divisor gives exactly DATA_WIDTH+1 cycles from the accept edge to the first cycle with out_valid=1.
- DONE: quotient, remainder and div_by_zero are held stable while out_valid=1 && !out_ready. On out_valid && out_ready, go to IDLE.
  - in_ready rises the next cycle. Back-to-back accept in the same cycle as the handshake is not supported.
- in_valid while busy has no effect. Operands are sampled only on the accept edge, so later input changes are ignored.
- Signed overflow (MIN / −1): the natural result is quotient=0x80000000, remainder=0, with no special path; div_by_zero=0.
- Arithmetic identity: the result always satisfies dividend == quotient*divisor + remainder (mod 2^DATA_WIDTH) for every non-zero divisor.
- The remainder sign follows the dividend, and |remainder| < |divisor|.

Decomposition:
- Shared package:
  - DATA_WIDTH default.
  - FSM state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - DIV0_QUOTIENT constant (all ones).
- One sub-module, div_step: combinational single iteration. Inputs are rem, the quo MSB and divisor_mag; outputs are next rem and the quotient bit. It is instantiated once and reused across cycles.

Test Plan:
- Reset mid-BUSY: accept 100/7, pull rst_n low at cycle 10 -> immediately in_ready=1, out_valid=0, quotient=0, remainder=0; then accept 9/3 -> quotient=3, remainder=0.
- Unsigned: dividend=100, divisor=7, is_signed=0 -> quotient=14, remainder=2; out_valid first high exactly 33 cycles after the accept edge.
- Signed: −100 (0xFFFFFF9C) / 7 -> quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). 100 / −7 -> quotient=−14, remainder=2. 0xFFFFFFFF/2 unsigned -> quotient=0x7FFFFFFF, remainder=1.
- Divide-by-zero: 1234/0 (signed and unsigned) -> next cycle out_valid=1, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0, div_by_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid/dividend -> outputs stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE and in_ready=1 the next cycle. Add 1000 random operand pairs checked against the arithmetic identity.
